// File: rtl/mem_responder.sv
// Memory-side responder: one 64-bit request becomes two 32-bit async-SRAM beats plus a memValid
// pulse. Define MEM_BOUND_CHECK_EN to reject addresses >= MAX_ADDR with memErr and no SRAM access.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [12:0] MAX_ADDR    = 13'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] address,
    input  logic        w_rn,
    input  logic        go,
    input  logic [63:0] dataToWrite,
    output logic        memValid,
    output logic [63:0] dataToRead,
    output logic        busy,
    output logic        memErr,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_dq_out,
    input  logic [31:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {StIdle, StBeat0, StBeat1, StDone, StRelease} state_e;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [12:0] addr_q;
    logic        w_rn_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] stage_lo_q;
    logic [63:0] rdata_q;
    logic        mem_valid_q;
    logic        mem_err_q;
    logic        err_req_q;
    logic [12:0] sram_addr_q;
    logic [31:0] sram_dq_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        beat_last;
    logic        addr_err;

    assign beat_last = (cnt_q == WaitLast);

`ifdef MEM_BOUND_CHECK_EN
    assign addr_err = (address >= MAX_ADDR);
`else
    logic unused_max_addr;
    assign unused_max_addr = ^MAX_ADDR;
    assign addr_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            w_rn_q      <= 1'b0;
            wdata_hi_q  <= '0;
            stage_lo_q  <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_err_q   <= 1'b0;
            err_req_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        addr_q     <= address;
                        w_rn_q     <= w_rn;
                        wdata_hi_q <= dataToWrite[63:32];
                        cnt_q      <= '0;
                        err_req_q  <= addr_err;
                        if (addr_err) begin
                            // Rejected request: no SRAM beats, memValid raised on leaving DONE.
                            state_q <= StDone;
                        end else begin
                            state_q     <= StBeat0;
                            sram_addr_q <= address;
                            ce_n_q      <= 1'b0;
                            oe_n_q      <= w_rn;
                            we_n_q      <= ~w_rn;
                            sram_dq_q   <= w_rn ? dataToWrite[31:0] : 32'h0;
                        end
                    end
                end
                StBeat0: begin
                    if (beat_last) begin
                        state_q     <= StBeat1;
                        cnt_q       <= '0;
                        sram_addr_q <= addr_q + 13'd1;
                        sram_dq_q   <= w_rn_q ? wdata_hi_q : 32'h0;
                        if (!w_rn_q) begin
                            stage_lo_q <= sram_dq_in;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StBeat1: begin
                    if (beat_last) begin
                        state_q     <= StDone;
                        mem_valid_q <= 1'b1;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        sram_dq_q   <= '0;
                        if (!w_rn_q) begin
                            rdata_q <= {sram_dq_in, stage_lo_q};
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q     <= StRelease;
                    mem_valid_q <= err_req_q;
                    mem_err_q   <= err_req_q;
                end
                StRelease: begin
                    mem_valid_q <= 1'b0;
                    mem_err_q   <= 1'b0;
                    if (!go) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign memValid    = mem_valid_q;
    assign memErr      = mem_err_q;
    assign dataToRead  = rdata_q;
    assign busy        = (state_q != StIdle);
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=1 instance on an SRAM model, plus WAIT_CYCLES=0/3
// instances for latency. Exercises the MEM_BOUND_CHECK_EN path when that macro is defined.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [12:0] address;
    logic        w_rn;
    logic        go;
    logic [63:0] data_to_write;
    logic        mem_valid;
    logic [63:0] data_to_read;
    logic        busy;
    logic        mem_err;
    logic [12:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic [31:0] sram_dq_in;
    logic        ce_n, oe_n, we_n;

    logic        go_l;
    logic        mv_w0, busy_w0, err_w0, ce_w0, oe_w0, we_w0;
    logic [63:0] rd_w0;
    logic [12:0] sa_w0;
    logic [31:0] dq_w0;
    logic        mv_w3, busy_w3, err_w3, ce_w3, oe_w3, we_w3;
    logic [63:0] rd_w3;
    logic [12:0] sa_w3;
    logic [31:0] dq_w3;

    mem_responder #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .address(address), .w_rn(w_rn), .go(go),
        .dataToWrite(data_to_write), .memValid(mem_valid), .dataToRead(data_to_read),
        .busy(busy), .memErr(mem_err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .address(13'd100), .w_rn(1'b0), .go(go_l),
        .dataToWrite(64'h0), .memValid(mv_w0), .dataToRead(rd_w0),
        .busy(busy_w0), .memErr(err_w0), .sram_addr(sa_w0), .sram_dq_out(dq_w0),
        .sram_dq_in(32'h0), .sram_ce_n(ce_w0), .sram_oe_n(oe_w0), .sram_we_n(we_w0)
    );

    mem_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .address(13'd100), .w_rn(1'b0), .go(go_l),
        .dataToWrite(64'h0), .memValid(mv_w3), .dataToRead(rd_w3),
        .busy(busy_w3), .memErr(err_w3), .sram_addr(sa_w3), .sram_dq_out(dq_w3),
        .sram_dq_in(32'h0), .sram_ce_n(ce_w3), .sram_oe_n(oe_w3), .sram_we_n(we_w3)
    );

    // Async SRAM model plus activity counters.
    logic [31:0] sram_mem [8192];
    int ce_cycles = 0;
    int mv_pulses = 0;
    assign sram_dq_in = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 32'h0;
    always @(posedge clk) begin
        if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq_out;
        if (!ce_n) ce_cycles <= ce_cycles + 1;
        if (mem_valid) mv_pulses <= mv_pulses + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int          lat;
    logic        err_at_valid;
    logic [12:0] b0_addr, b1_addr;
    logic [31:0] b0_dq, b1_dq;
    logic [2:0]  b0_strb;

    // One request on the WAIT_CYCLES=1 instance; go held `hold` cycles past the memValid pulse.
    task automatic do_req(input logic wr, input logic [12:0] a, input logic [63:0] d,
                          input int hold);
        @(negedge clk);
        go = 1'b1; w_rn = wr; address = a; data_to_write = d;
        @(posedge clk); #1;
        b0_addr = sram_addr; b0_dq = sram_dq_out; b0_strb = {ce_n, oe_n, we_n};
        b1_addr = '0; b1_dq = '0;
        lat = -1; err_at_valid = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                b1_addr = sram_addr; b1_dq = sram_dq_out;
            end
            if (mem_valid) begin
                lat = k; err_at_valid = mem_err;
            end
        end
        @(posedge clk); #1;
        check_eq("pulse_one_cycle", {63'h0, mem_valid}, 64'h0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("release_busy", {63'h0, busy}, 64'h1);
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        check_eq("back_to_idle", {63'h0, busy}, 64'h0);
    endtask

    int ce0, mv0, lat0, lat3, n0, n3;

    initial begin
        rst = 1'b0; go = 1'b0; go_l = 1'b0; w_rn = 1'b0; address = '0; data_to_write = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_flags", {61'h0, mem_valid, busy, mem_err}, 64'h0);
        check_eq("rst_rdata", data_to_read, 64'h0);
        check_eq("rst_sram_addr", {51'h0, sram_addr}, 64'h0);
        check_eq("rst_sram_dq", {32'h0, sram_dq_out}, 64'h0);
        check_eq("rst_strobes", {61'h0, ce_n, oe_n, we_n}, 64'h7);
        @(negedge clk);
        rst = 1'b1;

        // Write then read back at address 4.
        do_req(1'b1, 13'd4, 64'h0123456789ABCDEF, 0);
        check_eq("wr_latency", 64'(lat), 64'd4);
        check_eq("wr_b0_addr", {51'h0, b0_addr}, 64'd4);
        check_eq("wr_b0_strobes", {61'h0, b0_strb}, 64'h2);
        check_eq("wr_b0_dq", {32'h0, b0_dq}, 64'h89ABCDEF);
        check_eq("wr_b1_addr", {51'h0, b1_addr}, 64'd5);
        check_eq("wr_b1_dq", {32'h0, b1_dq}, 64'h01234567);
        check_eq("sram_word4", {32'h0, sram_mem[4]}, 64'h89ABCDEF);
        check_eq("sram_word5", {32'h0, sram_mem[5]}, 64'h01234567);
        check_eq("wr_keeps_rdata", data_to_read, 64'h0);

        ce0 = ce_cycles; mv0 = mv_pulses;
        do_req(1'b0, 13'd4, 64'h0, 3);
        check_eq("rd_latency", 64'(lat), 64'd4);
        check_eq("rd_b0_strobes", {61'h0, b0_strb}, 64'h1);
        check_eq("rd_data", data_to_read, 64'h0123456789ABCDEF);
        check_eq("rd_no_err", {63'h0, err_at_valid}, 64'h0);
        check_eq("rd_single_access", 64'(ce_cycles - ce0), 64'd4);
        check_eq("rd_single_valid", 64'(mv_pulses - mv0), 64'd1);

        // Address wrap 8191 -> 0.
        do_req(1'b1, 13'd8191, 64'h13579BDF_CAFEF00D, 0);
        check_eq("wrap_wr_b1_addr", {51'h0, b1_addr}, 64'd0);
        check_eq("sram_word8191", {32'h0, sram_mem[8191]}, 64'hCAFEF00D);
        check_eq("sram_word0", {32'h0, sram_mem[0]}, 64'h13579BDF);
        do_req(1'b0, 13'd8191, 64'h0, 0);
        check_eq("wrap_rd_b0_addr", {51'h0, b0_addr}, 64'd8191);
        check_eq("wrap_rd_b1_addr", {51'h0, b1_addr}, 64'd0);
        check_eq("wrap_rd_data", data_to_read, 64'h13579BDF_CAFEF00D);

        // Reset during BEAT1 of a write.
        mv0 = mv_pulses;
        @(negedge clk);
        go = 1'b1; w_rn = 1'b1; address = 13'd20; data_to_write = 64'hFEDCBA98_76543210;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        check_eq("beat1_strobes", {61'h0, ce_n, oe_n, we_n}, 64'h2);
        check_eq("beat1_addr", {51'h0, sram_addr}, 64'd21);
        rst = 1'b0;
        #1;
        check_eq("async_rst_strobes", {61'h0, ce_n, oe_n, we_n}, 64'h7);
        check_eq("async_rst_busy", {63'h0, busy}, 64'h0);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("rst_no_valid", 64'(mv_pulses - mv0), 64'd0);
        do_req(1'b0, 13'd4, 64'h0, 0);
        check_eq("post_rst_latency", 64'(lat), 64'd4);
        check_eq("post_rst_data", data_to_read, 64'h0123456789ABCDEF);

        // Latency for WAIT_CYCLES=0 and 3.
        @(negedge clk);
        go_l = 1'b1;
        @(posedge clk);
        lat0 = -1; lat3 = -1; n0 = 0; n3 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (mv_w0) begin n0++; if (lat0 < 0) lat0 = k; end
            if (mv_w3) begin n3++; if (lat3 < 0) lat3 = k; end
        end
        @(negedge clk);
        go_l = 1'b0;
        check_eq("w0_latency", 64'(lat0), 64'd2);
        check_eq("w3_latency", 64'(lat3), 64'd8);
        check_eq("w0_pulse_count", 64'(n0), 64'd1);
        check_eq("w3_pulse_count", 64'(n3), 64'd1);

        // Boundary address 1024.
        ce0 = ce_cycles;
        do_req(1'b0, 13'd1024, 64'h0, 0);
`ifdef MEM_BOUND_CHECK_EN
        check_eq("bound_latency", 64'(lat), 64'd1);
        check_eq("bound_err", {63'h0, err_at_valid}, 64'h1);
        check_eq("bound_no_sram", 64'(ce_cycles - ce0), 64'd0);
        check_eq("bound_rdata_kept", data_to_read, 64'h0123456789ABCDEF);
`else
        check_eq("addr1024_latency", 64'(lat), 64'd4);
        check_eq("addr1024_no_err", {63'h0, err_at_valid}, 64'h0);
        check_eq("addr1024_access", 64'(ce_cycles - ce0), 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
